// File: rtl/mac_requant_sign.sv
// Signed fixed-point dot product: accumulates LENGTH products at full precision,
// then rounds half-up, rescales by DECIMAL_POINT and saturates to WIDTH bits.
module mac_requant_sign #(
  parameter int WIDTH         = 8,
  parameter int DECIMAL_POINT = 6,
  parameter int LENGTH        = 16,
  parameter int ACC_WIDTH     = 2*WIDTH + $clog2(LENGTH)
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic signed [WIDTH-1:0] dataA,
  input  logic signed [WIDTH-1:0] dataW,
  input  logic                    enable,
  output logic signed [WIDTH-1:0] dataOut,
  output logic                    rdy
);

  localparam int CNT_W = $clog2(LENGTH);
  localparam int PW    = 2*WIDTH;
  localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(LENGTH-1);
  localparam logic signed [ACC_WIDTH:0] RND     = (ACC_WIDTH+1)'(1) << (DECIMAL_POINT-1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [PW-1:0]        prod_q, prod_d;
  logic                        first_q, last_q, v1_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, prod_ext;
  logic                        v2_q;
  logic signed [ACC_WIDTH:0]   rnd_sum, shifted;
  logic signed [WIDTH-1:0]     out_q, sat_d;
  logic                        rdy_q;

  // Stage 1: multiply and tag vector boundaries
  always_comb begin
    prod_d = dataA * dataW;
    cnt_d  = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      prod_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      v1_q  <= enable;
      if (enable) begin
        prod_q  <= prod_d;
        first_q <= (cnt_q == '0);
        last_q  <= (cnt_q == LAST_IDX);
      end
    end
  end

  // Stage 2: a first-tagged product reloads the sum, so no clear cycle is needed
  always_comb begin
    prod_ext = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
    acc_d    = first_q ? prod_ext : acc_q + prod_ext;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      acc_q <= '0;
      v2_q  <= 1'b0;
    end else begin
      v2_q <= v1_q & last_q;
      if (v1_q) begin
        acc_q <= acc_d;
      end
    end
  end

  // Stage 3: round half up, floor shift, saturate
  always_comb begin
    rnd_sum = {acc_q[ACC_WIDTH-1], acc_q} + RND;
    shifted = rnd_sum >>> DECIMAL_POINT;
    if (shifted > SAT_MAX) begin
      sat_d = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_d = SAT_MIN[WIDTH-1:0];
    end else begin
      sat_d = shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      out_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= v2_q;
      if (v2_q) begin
        out_q <= sat_d;
      end
    end
  end

  assign dataOut = out_q;
  assign rdy     = rdy_q;

endmodule

// File: doc/mac_requant_sign.md
# mac_requant_sign

Signed fixed-point dot-product stage that sits directly upstream of the activation stages (`relu_sign`, `leakyRelu_sign`, `hardtanh_sign`, `sigmoid_sign`). It takes a stream of activation/weight operand pairs and accumulates LENGTH products at full precision. It then rounds, rescales and saturates the sum back to WIDTH-bit fixed point with DECIMAL_POINT fractional bits. The result is emitted on a one-cycle `rdy` strobe, directly consumable as the `data` input of an activation stage.

## Interface
- WIDTH, 8: operand and result width, two's complement.
- DECIMAL_POINT, 6: fractional bits of operands and result.
- LENGTH, 16: products per dot product; must be ≥2.
- ACC_WIDTH, 2*WIDTH+$clog2(LENGTH): accumulator width; sum can never overflow.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  reset, synchronous, active-high.
- dataA  in  WIDTH  signed activation operand.
- dataW  in  WIDTH  signed weight operand.
- enable  in  1  operand pair valid; sampled each rising edge.
- dataOut  out  WIDTH  signed requantized dot product.
- rdy  out  1  one-cycle strobe: dataOut holds a new result.

## Operation
- There is no input backpressure; every edge with enable=1 accepts one pair.
- Stage 1: the product dataA*dataW (signed, 2*WIDTH bits) is registered with a `first` tag and a `last` tag.
  - `first` is set when the element counter is 0.
  - `last` is set when the element counter is LENGTH-1.
- Element counter runs 0..LENGTH-1:
  - It advances only on accepted pairs.
  - It wraps to 0 after LENGTH-1.
- Stage 2: the accumulator is updated.
  - On a `first` product it is loaded with that product; no separate clear is needed.
  - Otherwise the sign-extended product is added to it.
  - Stage-1 valid gates this update, so an enable=0 bubble holds all state.
- Stage 3 runs on a `last` product and uses the final sum S.
  - S includes that product.
  - R = (S + 2^(DECIMAL_POINT-1)) >>> DECIMAL_POINT, computed in ACC_WIDTH+1 bits. This is round half up, floor shift.
  - R is saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The result is registered into dataOut, and rdy is set.
- Back-to-back vectors run with no bubble: the first pair of vector k+1 may be accepted on the edge right after the last pair of vector k.
- The product of two Q(DECIMAL_POINT) values has 2*DECIMAL_POINT fractional bits. The shift restores DECIMAL_POINT fractional bits.

## Timing
- Reset values: dataOut=0, rdy=0, counter=0, accumulator=0, all stage valids=0.
- Reset mid-vector discards the partial sum and any in-flight product. No rdy is produced for the aborted vector.
- iRst=1 overrides enable on the same edge.
- Latency:
  - The last pair is accepted on edge n.
  - dataOut and rdy update on edge n+2.
  - rdy returns to 0 on edge n+3 unless another vector completes there.
- The rdy strobe does not depend on enable after edge n: enable=0 on edges n+1 and n+2 still produces the result.
- dataOut holds its value until the next result, including while rdy=0.
- Maximum throughput is one result every LENGTH cycles. rdy is never high on two consecutive edges when LENGTH≥2.

## Test plan
- Reset: drive iRst=1 for 2 edges with enable=1 and random operands -> dataOut=0 and rdy=0 throughout. First rdy comes only after 16 post-reset pairs.
- Basic value: pair 0 is A=64, W=32; pairs 1-15 are A=0, W=0 -> S=2048, R=(2048+32)>>>6=32. dataOut=32 (0.5), rdy high for exactly one cycle, 2 edges after pair 15.
- Rounding, one vector each with all remaining pairs zero:
  - A=1, W=96 -> dataOut=2.
  - A=-1, W=96 -> dataOut=-1.
  - A=1, W=31 -> dataOut=0.
- Saturation:
  - 16× (A=64, W=64) -> S=65536 -> dataOut=127.
  - 16× (A=-128, W=127) -> S=-260096 -> dataOut=-128.
  - 16× (A=-128, W=-128) -> S=262144, no accumulator overflow -> dataOut=127.
- Gaps and back-to-back:
  - Basic-value vector with enable=0 on every other edge -> same dataOut=32; rdy 2 edges after the last accepted pair.
  - Immediately followed, with no gap, by the 16× (64, 64) vector -> rdy strobes 16 cycles apart, values 32 then 127.
- Reset mid-vector: 8 pairs of (64, 64), iRst for one edge, then the basic-value vector -> single rdy with dataOut=32, none before.
